// File: rtl/router_pkg.sv
// Shared router definitions: lane count, arbiter FSM states and the idle
// output lane value used by every output-port arbiter.
package router_pkg;

  localparam int unsigned N_SRC = 16;
  localparam int unsigned SRC_W = 4;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic frame_n;
    logic valid_n;
    logic data;
  } lane_t;

  localparam lane_t IDLE_LANE = '{frame_n: 1'b1, valid_n: 1'b1, data: 1'b0};

  function automatic logic [N_SRC-1:0] src_onehot(input logic [SRC_W-1:0] idx);
    return N_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: first set request searching upward from
// last+1 and wrapping 15->0; shared by all output-port arbiters.
module rr_pick16
  import router_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SRC_W-1:0] last,
  output logic             any,
  output logic [SRC_W-1:0] idx,
  output logic [N_SRC-1:0] onehot
);

  logic             found;
  logic [SRC_W-1:0] cand;

  // i = N_SRC wraps back to last itself, so it is the lowest priority
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= N_SRC; i++) begin
      cand = last + SRC_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

  assign any    = found;
  assign onehot = found ? src_onehot(idx) : '0;

endmodule

// File: rtl/encode_arbiter.sv
// Output-port arbiter: round-robin grants one of 16 source lanes for a whole
// packet and re-serialises its frame/valid/data with one registered cycle.
module encode_arbiter
  import router_pkg::*;
#(
  parameter int unsigned GAP_CYCLES    = 1,
  parameter int unsigned START_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] request_i,
  input  logic [N_SRC-1:0] frame_i,
  input  logic [N_SRC-1:0] valid_i,
  input  logic [N_SRC-1:0] din_i,
  output logic             frameo_n,
  output logic             valido_n,
  output logic             dout,
  output logic [N_SRC-1:0] grant_o,
  output logic [SRC_W-1:0] src_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  arb_state_e       state_q,   state_d;
  lane_t            out_q,     out_d;
  logic [N_SRC-1:0] grant_q,   grant_d;
  logic [SRC_W-1:0] src_q,     src_d;
  logic [SRC_W-1:0] last_q,    last_d;
  logic             started_q, started_d;
  logic [CNT_W-1:0] tcnt_q,    tcnt_d;
  logic [CNT_W-1:0] gcnt_q,    gcnt_d;
  logic             busy_q,    busy_d;
  logic             err_q,     err_d;

  logic             pick_any;
  logic [SRC_W-1:0] pick_idx;
  logic [N_SRC-1:0] pick_onehot;

  rr_pick16 u_pick (
    .req    (request_i),
    .last   (last_q),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      out_q     <= IDLE_LANE;
      grant_q   <= '0;
      src_q     <= '0;
      last_q    <= SRC_W'(N_SRC - 1);
      started_q <= 1'b0;
      tcnt_q    <= '0;
      gcnt_q    <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      grant_q   <= grant_d;
      src_q     <= src_d;
      last_q    <= last_d;
      started_q <= started_d;
      tcnt_q    <= tcnt_d;
      gcnt_q    <= gcnt_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  // Only the granted lane is ever read, and abort is tested before its
  // frame/valid/data so unrequested (possibly X) lanes never reach the pins.
  always_comb begin
    state_d   = state_q;
    out_d     = IDLE_LANE;
    grant_d   = grant_q;
    src_d     = src_q;
    last_d    = last_q;
    started_d = started_q;
    tcnt_d    = tcnt_q;
    gcnt_d    = gcnt_q;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d   = pick_onehot;
          src_d     = pick_idx;
          last_d    = pick_idx;
          started_d = 1'b0;
          tcnt_d    = '0;
          state_d   = XFER;
        end
      end

      XFER: begin
        if (!request_i[src_q]) begin
          err_d   = 1'b1;
          grant_d = '0;
          gcnt_d  = '0;
          state_d = GAP;
        end else if (!started_q && (tcnt_q == TO_LAST)) begin
          err_d   = 1'b1;
          grant_d = '0;
          gcnt_d  = '0;
          state_d = GAP;
        end else begin
          out_d.frame_n = frame_i[src_q];
          out_d.valid_n = valid_i[src_q];
          out_d.data    = din_i[src_q];
          if (!frame_i[src_q]) begin
            started_d = 1'b1;
          end
          if (started_q && frame_i[src_q]) begin
            grant_d = '0;
            gcnt_d  = '0;
            state_d = GAP;
          end
          if (tcnt_q != '1) begin
            tcnt_d = tcnt_q + CNT_W'(1);
          end
        end
      end

      GAP: begin
        if (gcnt_q >= GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gcnt_d = gcnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign frameo_n = out_q.frame_n;
  assign valido_n = out_q.valid_n;
  assign dout     = out_q.data;
  assign grant_o  = grant_q;
  assign src_o    = src_q;
  assign busy_o   = busy_q;
  assign err_o    = err_q;

endmodule
